// File: rtl/gray_counter_sequencer.sv
// Run sequencer and self-checker for a WIDTH-bit Gray counter: clears it, enables it
// for run_len cycles, compares every active cycle against its own binary-to-Gray model.
module gray_counter_sequencer #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic             abort,
  input  logic [WIDTH-1:0] salida_gray,
  output logic             cnt_enable,
  output logic             cnt_clear,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] steps_done,
  output logic             error,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [LEN_W-1:0] len_q;
  logic [WIDTH-1:0] exp_bin;
  logic             take_abort;
  logic             check_en;
  logic             mismatch;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign busy       = (state != IDLE);
  assign take_abort = abort && ((state == CLEAR) || (state == RUN) || (state == DRAIN));
  assign check_en   = !take_abort && ((state == RUN) || (state == DRAIN));
  assign mismatch   = check_en && (salida_gray != to_gray(exp_bin));

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = (run_len != '0) ? CLEAR : DONE;
      end
      CLEAR: next_state = take_abort ? IDLE : RUN;
      RUN: begin
        if (take_abort)                             next_state = IDLE;
        else if (steps_done == len_q - LEN_W'(1))   next_state = DRAIN;
      end
      DRAIN:   next_state = take_abort ? IDLE : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are registered from next_state so they line up with the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= '0;
      exp_bin    <= '0;
      steps_done <= '0;
      error      <= 1'b0;
      err_count  <= '0;
      cnt_enable <= 1'b0;
      cnt_clear  <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= next_state;
      cnt_enable <= (next_state == RUN);
      cnt_clear  <= (next_state == CLEAR);
      done       <= (next_state == DONE);
      aborted    <= take_abort;

      case (state)
        IDLE: begin
          if (start) begin
            steps_done <= '0;
            error      <= 1'b0;
            err_count  <= '0;
            if (run_len != '0) len_q <= run_len;
          end
        end
        CLEAR: begin
          if (!take_abort) exp_bin <= '0;
        end
        RUN: begin
          if (!take_abort) begin
            exp_bin    <= exp_bin + WIDTH'(1);
            steps_done <= steps_done + LEN_W'(1);
          end
        end
        default: ;
      endcase

      if (mismatch) begin
        error <= 1'b1;
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gray_counter_sequencer.sv
// Self-checking bench: a behavioural Gray counter with per-step fault injection feeds
// the sequencer; directed table, hand-written corner sequences and random runs.
module tb_gray_counter_sequencer;

  localparam int WIDTH = 5;
  localparam int LEN_W = 8;
  localparam int ERR_W = 8;
  localparam int MAXI  = 300;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] run_len;
  logic             abort;
  logic [WIDTH-1:0] salida_gray;
  logic             cnt_enable;
  logic             cnt_clear;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [LEN_W-1:0] steps_done;
  logic             error;
  logic [ERR_W-1:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  gray_counter_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .run_len(run_len), .abort(abort),
    .salida_gray(salida_gray), .cnt_enable(cnt_enable), .cnt_clear(cnt_clear),
    .busy(busy), .done(done), .aborted(aborted), .steps_done(steps_done),
    .error(error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Counter model: cnt_int is the unwrapped step count since the last clear, which
  // also indexes the fault mask so each observed step can be corrupted individually.
  int         cnt_int = 0;
  logic [4:0] fault_mask [MAXI];

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b % 32);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [4:0] mask_at(input int c);
    return (c < MAXI) ? fault_mask[c] : 5'd0;
  endfunction

  always @(posedge clk) begin
    if (cnt_clear)       cnt_int <= 0;
    else if (cnt_enable) cnt_int <= cnt_int + 1;
  end

  always_comb salida_gray = gray5(cnt_int) ^ mask_at(cnt_int);

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_masks(input int idx, input logic [4:0] xv);
    for (int i = 0; i < MAXI; i++)
      fault_mask[i] = (idx == -2 || i == idx) ? xv : 5'd0;
  endtask

  // Leaves the bench in cycle 1 (start was sampled at cycle 0).
  task automatic start_run(input int len);
    @(negedge clk);
    start   = 1'b1;
    run_len = LEN_W'(len);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    while (!done) begin
      if (cyc >= 600) begin
        chk("done_timeout", 0, 1);
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_run(input int len, output int lat, output int en_n,
                        output int clr_n, output int ovl, output int busy_n);
    start_run(len);
    chk("err_cleared_on_start", int'(error), 0);
    chk("errcnt_cleared_on_start", int'(err_count), 0);
    chk("steps_cleared_on_start", int'(steps_done), 0);
    lat = 1; en_n = 0; clr_n = 0; ovl = 0; busy_n = 0;
    forever begin
      ovl    += int'(cnt_enable && cnt_clear);
      en_n   += int'(cnt_enable);
      clr_n  += int'(cnt_clear);
      busy_n += int'(busy);
      if (done) break;
      if (lat >= 600) begin
        chk("done_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    int         len;
    int         fidx;
    logic [4:0] fxor;
    int         lat;
    int         steps;
    int         err;
    int         cnt;
    bit         chkg;
    logic [4:0] g;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int lat, en_n, clr_n, ovl, busy_n, cyc, len, exp_cnt;

    tbl[0] = '{3,   -1, 5'b00000,   6,   3, 0,   0, 1'b1, 5'b00010};
    tbl[1] = '{0,   -1, 5'b00000,   1,   0, 0,   0, 1'b0, 5'b00000};
    tbl[2] = '{40,  -1, 5'b00000,  43,  40, 0,   0, 1'b1, 5'b01100};
    tbl[3] = '{10,   4, 5'b00001,  13,  10, 1,   1, 1'b1, 5'b01111};
    tbl[4] = '{1,   -1, 5'b00000,   4,   1, 0,   0, 1'b1, 5'b00001};
    tbl[5] = '{32,  -1, 5'b00000,  35,  32, 0,   0, 1'b1, 5'b00000};
    tbl[6] = '{5,    5, 5'b10000,   8,   5, 1,   1, 1'b0, 5'b00000};
    tbl[7] = '{255, -2, 5'b00001, 258, 255, 1, 255, 1'b0, 5'b00000};
    tbl[8] = '{2,   -1, 5'b00000,   5,   2, 0,   0, 1'b1, 5'b00011};
    tbl[9] = '{31,  -1, 5'b00000,  34,  31, 0,   0, 1'b1, 5'b10000};

    set_masks(-1, 5'd0);
    reset = 1'b1; start = 1'b1; run_len = 8'd5; abort = 1'b0;

    // Reset held two cycles with start asserted.
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_enable", int'(cnt_enable), 0);
    chk("rst_clear", int'(cnt_clear), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_steps", int'(steps_done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_errcnt", int'(err_count), 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored_busy", int'(busy), 0);

    foreach (tbl[k]) begin
      set_masks(tbl[k].fidx, tbl[k].fxor);
      do_run(tbl[k].len, lat, en_n, clr_n, ovl, busy_n);
      chk($sformatf("tbl%0d_latency", k), lat, tbl[k].lat);
      chk($sformatf("tbl%0d_enables", k), en_n, tbl[k].len);
      chk($sformatf("tbl%0d_clears", k), clr_n, (tbl[k].len != 0) ? 1 : 0);
      chk($sformatf("tbl%0d_overlap", k), ovl, 0);
      chk($sformatf("tbl%0d_busy_cycles", k), busy_n, tbl[k].lat);
      chk($sformatf("tbl%0d_steps", k), int'(steps_done), tbl[k].steps);
      chk($sformatf("tbl%0d_error", k), int'(error), tbl[k].err);
      chk($sformatf("tbl%0d_errcnt", k), int'(err_count), tbl[k].cnt);
      if (tbl[k].chkg) chk($sformatf("tbl%0d_final_gray", k), int'(salida_gray), int'(tbl[k].g));
      @(negedge clk);
      chk($sformatf("tbl%0d_done_one_cycle", k), int'(done), 0);
      chk($sformatf("tbl%0d_idle_after", k), int'(busy), 0);
    end
    set_masks(-1, 5'd0);

    // Abort in the 2nd RUN cycle; a start issued during RUN must be ignored.
    start_run(20);
    @(negedge clk); start = 1'b1; run_len = 8'd5;
    @(negedge clk); start = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abrun_aborted", int'(aborted), 1);
    chk("abrun_busy", int'(busy), 0);
    chk("abrun_done", int'(done), 0);
    chk("abrun_steps", int'(steps_done), 1);
    chk("abrun_enable", int'(cnt_enable), 0);
    @(negedge clk);
    chk("abrun_pulse_end", int'(aborted), 0);
    chk("abrun_stays_idle", int'(busy), 0);

    // start during RUN does not re-latch run_len.
    start_run(6);
    @(negedge clk); start = 1'b1; run_len = 8'd2;
    @(negedge clk); start = 1'b0;
    cyc = 3;
    wait_done(cyc);
    chk("relatch_latency", cyc, 9);
    chk("relatch_steps", int'(steps_done), 6);
    @(negedge clk);
    chk("relatch_idle", int'(busy), 0);

    // Abort in CLEAR.
    start_run(8);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abclr_aborted", int'(aborted), 1);
    chk("abclr_steps", int'(steps_done), 0);
    chk("abclr_clear_dropped", int'(cnt_clear), 0);

    // Abort in DRAIN (cycle len+2).
    start_run(4);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abdrain_aborted", int'(aborted), 1);
    chk("abdrain_done", int'(done), 0);
    chk("abdrain_steps", int'(steps_done), 4);
    @(negedge clk);
    chk("abdrain_no_late_done", int'(done), 0);

    // Abort in DONE and in IDLE is ignored.
    start_run(2);
    cyc = 1;
    wait_done(cyc);
    abort = 1'b1;
    @(negedge clk);
    chk("abdone_ignored", int'(aborted), 0);
    @(negedge clk); abort = 1'b0;
    chk("abidle_ignored", int'(aborted), 0);

    // Reset mid-run.
    start_run(20);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_steps", int'(steps_done), 0);
    chk("midrst_enable", int'(cnt_enable), 0);

    // Random runs with random per-step corruption, checked against step-level expectations.
    for (int r = 0; r < 30; r++) begin
      len = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 70));
      for (int i = 0; i < MAXI; i++)
        fault_mask[i] = ($urandom % 6 == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      exp_cnt = 0;
      if (len > 0)
        for (int j = 0; j <= len; j++)
          if (fault_mask[j] != 5'd0) exp_cnt++;
      if (exp_cnt > 255) exp_cnt = 255;
      do_run(len, lat, en_n, clr_n, ovl, busy_n);
      chk($sformatf("rnd%0d_latency", r), lat, (len == 0) ? 1 : len + 3);
      chk($sformatf("rnd%0d_enables", r), en_n, len);
      chk($sformatf("rnd%0d_overlap", r), ovl, 0);
      chk($sformatf("rnd%0d_steps", r), int'(steps_done), len);
      chk($sformatf("rnd%0d_errcnt", r), int'(err_count), exp_cnt);
      chk($sformatf("rnd%0d_error", r), int'(error), (exp_cnt != 0) ? 1 : 0);
      if (len > 0)
        chk($sformatf("rnd%0d_final", r), int'(salida_gray),
            int'(gray5(len) ^ fault_mask[len]));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
